mdu_seq: RTL and testbench



---
 rtl/mdu_seq_if.sv | 17 +
 rtl/mdu_seq.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mdu_seq.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_seq_if.sv
// Request/result bundle between the EX-stage decoder controls and the
// multiply/divide unit: MDUStart/MDUOp plus forwarded operands in, busy and
// the HI/LO registers out.
interface mdu_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit owning the HI/LO registers.
// mult/multu/div/divu hold busy for a fixed number of cycles and write HI/LO
// on the edge where busy falls; mthi/mtlo write immediately when idle.
// Requests are ignored entirely while busy; the hazard unit stalls instead.
// Optional macro MDU_MADD_EN adds madd/maddu/msub/msubu (ops 9..12) with the
// multiply latency; without it those ops are no-ops.
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_seq_if.slave  io_mdu
);
    // Op codes that change state; 0 (none), 5 (mfhi), 6 (mflo) and any
    // other code fall through to "no state change".
    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MTHI  = 5'd7;
    localparam logic [4:0] OP_MTLO  = 5'd8;
`ifdef MDU_MADD_EN
    localparam logic [4:0] OP_MADD  = 5'd9;
    localparam logic [4:0] OP_MADDU = 5'd10;
    localparam logic [4:0] OP_MSUB  = 5'd11;
    localparam logic [4:0] OP_MSUBU = 5'd12;
`endif

    localparam logic [3:0]       LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0]       LP_DIV_CNT  = 4'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] LP_ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] LP_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_cnt;
    logic [4:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_is_long;
    logic [3:0]         w_load_cnt;
    logic               w_busy;
    logic               w_done;
    logic               w_signed;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_divres;
    logic               w_res_wr;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Full 2*WIDTH product; signed mode sign-extends both operands so the
    // truncated unsigned product equals the two's complement product.
    function automatic logic [2*WIDTH-1:0] f_mul(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic sgn);
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        return xe * ye;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so
    // most-negative / -1 wraps naturally to quotient = dividend, rem = 0.
    // A zero divisor is replaced by one only to keep the divider defined;
    // the caller never writes that result.
    function automatic logic [2*WIDTH-1:0] f_div(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic sgn);
        logic             neg_x;
        logic             neg_y;
        logic [WIDTH-1:0] mag_x;
        logic [WIDTH-1:0] mag_y;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        neg_x = sgn & x[WIDTH-1];
        neg_y = sgn & y[WIDTH-1];
        mag_x = neg_x ? -x : x;
        mag_y = neg_y ? -y : y;
        mag_y = (mag_y == LP_ZERO) ? LP_ONE : mag_y;
        q     = mag_x / mag_y;
        r     = mag_x % mag_y;
        q     = (neg_x ^ neg_y) ? -q : q;
        r     = neg_x ? -r : r;
        return {r, q};
    endfunction

    assign w_accept = io_mdu.start && (r_state == S_IDLE);

    // Classify the incoming op: multi-cycle or not, and its busy length.
    always_comb begin
        w_is_long  = 1'b0;
        w_load_cnt = 4'd0;
        case (io_mdu.op)
            OP_MULT, OP_MULTU: begin
                w_is_long  = 1'b1;
                w_load_cnt = LP_MULT_CNT;
            end
            OP_DIV, OP_DIVU: begin
                w_is_long  = 1'b1;
                w_load_cnt = LP_DIV_CNT;
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                w_is_long  = 1'b1;
                w_load_cnt = LP_MULT_CNT;
            end
`endif
            default: begin
                w_is_long  = 1'b0;
                w_load_cnt = 4'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: idle until a multi-cycle op is accepted, busy until
    // the counter's last cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_long) begin
                    w_next_state = S_BUSY;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BUSY: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the state register: busy, and the completion edge.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_BUSY: begin
                w_busy = 1'b1;
                w_done = (r_cnt == 4'd1);
            end
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Signedness of the latched op.
    always_comb begin
        w_signed = 1'b0;
        case (r_op)
            OP_MULT, OP_DIV: w_signed = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MSUB: w_signed = 1'b1;
`endif
            default: w_signed = 1'b0;
        endcase
    end

    assign w_prod   = f_mul(r_a, r_b, w_signed);
    assign w_divres = f_div(r_a, r_b, w_signed);

    // HI/LO value to commit at completion; divide by zero commits nothing.
    // Accumulating ops use the HI/LO current at completion.
    always_comb begin
        w_res_wr = 1'b0;
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            OP_MULT, OP_MULTU: begin
                w_res_wr             = 1'b1;
                {w_res_hi, w_res_lo} = w_prod;
            end
            OP_DIV, OP_DIVU: begin
                if (r_b != LP_ZERO) begin
                    w_res_wr             = 1'b1;
                    {w_res_hi, w_res_lo} = w_divres;
                end else begin
                    w_res_wr = 1'b0;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                w_res_wr             = 1'b1;
                {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod;
            end
            OP_MSUB, OP_MSUBU: begin
                w_res_wr             = 1'b1;
                {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_prod;
            end
`endif
            default: w_res_wr = 1'b0;
        endcase
    end

    // Operand/op latch and busy-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 4'd0;
            r_op  <= 5'd0;
            r_a   <= LP_ZERO;
            r_b   <= LP_ZERO;
        end else if (w_accept && w_is_long) begin
            r_cnt <= w_load_cnt;
            r_op  <= io_mdu.op;
            r_a   <= io_mdu.a;
            r_b   <= io_mdu.b;
        end else if (w_busy && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // HI/LO registers: completion writes, or mthi/mtlo when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= LP_ZERO;
            r_lo <= LP_ZERO;
        end else if (w_done && w_res_wr) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (w_accept && (io_mdu.op == OP_MTHI)) begin
            r_hi <= io_mdu.a;
        end else if (w_accept && (io_mdu.op == OP_MTLO)) begin
            r_lo <= io_mdu.a;
        end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
        end
    end

    assign io_mdu.busy = w_busy;
    assign io_mdu.hi   = r_hi;
    assign io_mdu.lo   = r_lo;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed scenarios plus randomized ops
// against a plain-arithmetic HI/LO reference model.
module tb_mdu_seq;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(32)) u_if ();

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_mdu (u_if)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Present a request for one edge; returns at the following negedge.
    task automatic do_issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.start = 1'b1; u_if.op = op; u_if.a = a; u_if.b = b;
        @(posedge clk); #1;
        u_if.start = 1'b0; u_if.op = 5'd0; u_if.a = $urandom; u_if.b = $urandom;
        @(negedge clk);
    endtask

    // Count negedges with busy high; bounded.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (u_if.busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    function automatic int exp_cycles(input logic [4:0] op);
        if (op == 5'd1 || op == 5'd2) return MC;
        if (op == 5'd3 || op == 5'd4) return DC;
`ifdef MDU_MADD_EN
        if (op >= 5'd9 && op <= 5'd12) return MC;
`endif
        return 0;
    endfunction

    // Reference model: effect of one accepted op on HI/LO.
    task automatic model_exec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            5'd1: begin p = sa * sb; {m_hi, m_lo} = p; end
            5'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            5'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            5'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
            5'd7: m_hi = a;
            5'd8: m_lo = a;
`ifdef MDU_MADD_EN
            5'd9:  begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} + p; end
            5'd10: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = {m_hi, m_lo} + p; end
            5'd11: begin p = sa * sb; {m_hi, m_lo} = {m_hi, m_lo} - p; end
            5'd12: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = {m_hi, m_lo} - p; end
`endif
            default: ;
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b1; u_if.start = 1'b0; u_if.op = 5'd0; u_if.a = 32'd0; u_if.b = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        m_hi = 32'd0; m_lo = 32'd0;
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", u_if.busy); end
        checks++; if (u_if.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", u_if.hi); end
        checks++; if (u_if.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", u_if.lo); end
    endtask

    task automatic test_mult();
        int cnt;
        do_issue(5'd1, 32'hFFFFFFFE, 32'd3); wait_idle(cnt); model_exec(5'd1, 32'hFFFFFFFE, 32'd3);
        checks++; if (cnt !== MC) begin errors++; $display("FAIL mult_busy got %0d exp %0d", cnt, MC); end
        checks++; if (u_if.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", u_if.hi); end
        checks++; if (u_if.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", u_if.lo); end
        do_issue(5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle(cnt); model_exec(5'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++; if (cnt !== MC) begin errors++; $display("FAIL multu_busy got %0d exp %0d", cnt, MC); end
        checks++; if (u_if.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h exp fffffffe", u_if.hi); end
        checks++; if (u_if.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h exp 00000001", u_if.lo); end
    endtask

    task automatic test_div();
        int cnt;
        do_issue(5'd3, 32'hFFFFFFF9, 32'd2); wait_idle(cnt); model_exec(5'd3, 32'hFFFFFFF9, 32'd2);
        checks++; if (cnt !== DC) begin errors++; $display("FAIL div_busy got %0d exp %0d", cnt, DC); end
        checks++; if (u_if.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h exp fffffffd", u_if.lo); end
        checks++; if (u_if.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h exp ffffffff", u_if.hi); end
        do_issue(5'd7, 32'h11, 32'd0); model_exec(5'd7, 32'h11, 32'd0);
        do_issue(5'd8, 32'h22, 32'd0); model_exec(5'd8, 32'h22, 32'd0);
        do_issue(5'd4, 32'd7, 32'd0); wait_idle(cnt);
        checks++; if (cnt !== DC) begin errors++; $display("FAIL divz_busy got %0d exp %0d", cnt, DC); end
        checks++; if (u_if.hi !== 32'h11) begin errors++; $display("FAIL divz_hi got %h exp 00000011", u_if.hi); end
        checks++; if (u_if.lo !== 32'h22) begin errors++; $display("FAIL divz_lo got %h exp 00000022", u_if.lo); end
        do_issue(5'd3, 32'h80000000, 32'hFFFFFFFF); wait_idle(cnt); model_exec(5'd3, 32'h80000000, 32'hFFFFFFFF);
        checks++; if (u_if.lo !== 32'h80000000) begin errors++; $display("FAIL divovf_lo got %h exp 80000000", u_if.lo); end
        checks++; if (u_if.hi !== 32'd0) begin errors++; $display("FAIL divovf_hi got %h exp 00000000", u_if.hi); end
    endtask

    task automatic test_mt_busy();
        int cnt;
        do_issue(5'd3, 32'd100, 32'd7);
        cnt = 0;
        while (u_if.busy === 1'b1 && cnt < 40) begin
            if (cnt == 2) begin
                u_if.start = 1'b1; u_if.op = 5'd8; u_if.a = 32'h1234;
            end else begin
                u_if.start = 1'b0; u_if.op = 5'd0;
            end
            cnt++;
            @(negedge clk);
        end
        u_if.start = 1'b0; u_if.op = 5'd0;
        model_exec(5'd3, 32'd100, 32'd7);
        checks++; if (cnt !== DC) begin errors++; $display("FAIL mtbusy_busy got %0d exp %0d", cnt, DC); end
        checks++; if (u_if.lo !== 32'd14) begin errors++; $display("FAIL mtbusy_lo got %h exp 0000000e", u_if.lo); end
        checks++; if (u_if.hi !== 32'd2) begin errors++; $display("FAIL mtbusy_hi got %h exp 00000002", u_if.hi); end
        do_issue(5'd8, 32'h1234, 32'd0); model_exec(5'd8, 32'h1234, 32'd0);
        checks++; if (u_if.lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo got %h exp 00001234", u_if.lo); end
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %b exp 0", u_if.busy); end
        @(negedge clk);
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy2 got %b exp 0", u_if.busy); end
    endtask

    task automatic test_reset_mid();
        int cnt;
        do_issue(5'd7, 32'hAAAA, 32'd0); model_exec(5'd7, 32'hAAAA, 32'd0);
        do_issue(5'd1, 32'd9, 32'd9);
        repeat (2) @(negedge clk);
        checks++; if (u_if.busy !== 1'b1) begin errors++; $display("FAIL rstmid_prebusy got %b exp 1", u_if.busy); end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        m_hi = 32'd0; m_lo = 32'd0;
        checks++; if (u_if.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", u_if.busy); end
        checks++; if (u_if.hi !== 32'd0 || u_if.lo !== 32'd0) begin errors++; $display("FAIL rstmid_hilo got %h/%h exp 0/0", u_if.hi, u_if.lo); end
        repeat (8) @(negedge clk);
        checks++; if (u_if.busy !== 1'b0 || u_if.hi !== 32'd0 || u_if.lo !== 32'd0) begin errors++; $display("FAIL rstmid_late got busy %b hi %h lo %h exp 0/0/0", u_if.busy, u_if.hi, u_if.lo); end
        do_issue(5'd1, 32'd6, 32'd7); wait_idle(cnt); model_exec(5'd1, 32'd6, 32'd7);
        checks++; if (cnt !== MC) begin errors++; $display("FAIL rst6x7_busy got %0d exp %0d", cnt, MC); end
        checks++; if (u_if.lo !== 32'd42 || u_if.hi !== 32'd0) begin errors++; $display("FAIL rst6x7_res got %h/%h exp 0/2a", u_if.hi, u_if.lo); end
    endtask

    task automatic test_back_to_back();
        int          cnt;
        logic [31:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'd1;
        do_issue(5'd2, a1, b1); wait_idle(cnt); model_exec(5'd2, a1, b1);
        checks++; if (cnt !== MC || u_if.hi !== m_hi || u_if.lo !== m_lo) begin errors++; $display("FAIL b2b_first got %0d %h %h exp %0d %h %h", cnt, u_if.hi, u_if.lo, MC, m_hi, m_lo); end
        do_issue(5'd4, a2, b2); wait_idle(cnt); model_exec(5'd4, a2, b2);
        checks++; if (cnt !== DC) begin errors++; $display("FAIL b2b_busy got %0d exp %0d", cnt, DC); end
        checks++; if (u_if.hi !== m_hi || u_if.lo !== m_lo) begin errors++; $display("FAIL b2b_res got %h %h exp %h %h", u_if.hi, u_if.lo, m_hi, m_lo); end
    endtask

    task automatic test_noop();
        logic [4:0] ops [$];
        ops = '{5'd0, 5'd5, 5'd6, 5'd13, 5'd31};
`ifndef MDU_MADD_EN
        ops.push_back(5'd9); ops.push_back(5'd10); ops.push_back(5'd11); ops.push_back(5'd12);
`endif
        foreach (ops[i]) begin
            do_issue(ops[i], $urandom, $urandom);
            checks++; if (u_if.busy !== 1'b0 || u_if.hi !== m_hi || u_if.lo !== m_lo) begin errors++; $display("FAIL noop_op%0d got busy %b hi %h lo %h exp 0 %h %h", ops[i], u_if.busy, u_if.hi, u_if.lo, m_hi, m_lo); end
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        int cnt;
        do_issue(5'd7, 32'd0, 32'd0); model_exec(5'd7, 32'd0, 32'd0);
        do_issue(5'd8, 32'hFFFFFFFF, 32'd0); model_exec(5'd8, 32'hFFFFFFFF, 32'd0);
        do_issue(5'd9, 32'd1, 32'd1); wait_idle(cnt); model_exec(5'd9, 32'd1, 32'd1);
        checks++; if (cnt !== MC) begin errors++; $display("FAIL madd_busy got %0d exp %0d", cnt, MC); end
        checks++; if (u_if.hi !== 32'd1 || u_if.lo !== 32'd0) begin errors++; $display("FAIL madd_res got %h %h exp 00000001 00000000", u_if.hi, u_if.lo); end
    endtask
`endif

    task automatic test_random();
        int          cnt;
        logic [4:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom;
                op = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd8;
                do_issue(op, a, 32'd0); model_exec(op, a, 32'd0);
            end
            op = 5'($urandom_range(1, 4));
`ifdef MDU_MADD_EN
            if ($urandom_range(0, 1) == 1) op = op + 5'd8;
`endif
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = 32'($urandom_range(0, 50)) - 32'd25; b = 32'($urandom_range(0, 10)) - 32'd5; end
                default: ;
            endcase
            do_issue(op, a, b); wait_idle(cnt); model_exec(op, a, b);
            checks++; if (cnt !== exp_cycles(op)) begin errors++; $display("FAIL rnd%0d_busy op %0d got %0d exp %0d", i, op, cnt, exp_cycles(op)); end
            checks++; if (u_if.hi !== m_hi || u_if.lo !== m_lo) begin errors++; $display("FAIL rnd%0d_res op %0d a %h b %h got %h %h exp %h %h", i, op, a, b, u_if.hi, u_if.lo, m_hi, m_lo); end
        end
    endtask

    initial begin
        u_if.start = 1'b0; u_if.op = 5'd0; u_if.a = 32'd0; u_if.b = 32'd0; reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_mt_busy();
        test_reset_mid();
        test_back_to_back();
        test_noop();
`ifdef MDU_MADD_EN
        test_madd();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
